// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b types: opcodes, control word, BHT and resolver types
package lc3b_types;

    typedef enum logic [3:0] {
        op_br   = 4'b0000,
        op_add  = 4'b0001,
        op_ldb  = 4'b0010,
        op_stb  = 4'b0011,
        op_jsr  = 4'b0100,
        op_and  = 4'b0101,
        op_ldr  = 4'b0110,
        op_str  = 4'b0111,
        op_rti  = 4'b1000,
        op_not  = 4'b1001,
        op_ldi  = 4'b1010,
        op_sti  = 4'b1011,
        op_jmp  = 4'b1100,
        op_shf  = 4'b1101,
        op_lea  = 4'b1110,
        op_trap = 4'b1111
    } lc3b_opcode;

    typedef struct packed {
        lc3b_opcode opcode;
        logic       is_uncond_control;
    } lc3b_control_word;

    typedef logic [1:0] lc3b_bht_count;

    localparam int BHT_ENTRIES = 8;
    localparam int BHT_INDEX_W = 3;
    localparam lc3b_bht_count BHT_RESET_COUNT = 2'b01;

    typedef enum logic {
        RS_IDLE  = 1'b0,
        RS_FLUSH = 1'b1
    } resolver_state_t;

endpackage

// File: rtl/bht_counter.sv
// rtl/bht_counter.sv - one 2-bit saturating branch history counter
module bht_counter
    import lc3b_types::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          dec,
    output lc3b_bht_count count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= BHT_RESET_COUNT;
        end else if (inc && count != 2'b11) begin
            count <= count + 2'b01;
        end else if (dec && count != 2'b00) begin
            count <= count - 2'b01;
        end
    end

endmodule

// File: rtl/wb_branch_resolver.sv
// rtl/wb_branch_resolver.sv - resolves control ops at WB, issues redirects, trains the BHT
module wb_branch_resolver
    import lc3b_types::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load_mem_wb,
    input  logic             wb_is_nop,
    input  lc3b_control_word wb_cntrl,
    input  logic             wb_branch_prediction,
    input  logic             wb_take_jump,
    input  logic [15:0]      wb_pc,
    input  logic [15:0]      wb_pc_mux,
    input  logic [15:0]      wb_flush_pc,
    input  logic             wb_check_target,
    input  logic [15:0]      fetch_pc,
    output logic             predict_taken,
    output logic             flush,
    output logic             redirect_valid,
    output logic [15:0]      redirect_pc,
    output logic [15:0]      branch_count,
    output logic [15:0]      mispredict_count
);

    resolver_state_t        state;
    lc3b_bht_count          bht_count [BHT_ENTRIES];
    logic                   retire;
    logic                   is_cond_br;
    logic                   is_control;
    logic                   mispredict;
    logic                   bht_update;
    logic [BHT_INDEX_W-1:0] wb_index;

    // Retirements seen while flushing belong to the wrong path and are dropped.
    assign retire     = load_mem_wb & ~wb_is_nop & (state == RS_IDLE);
    assign is_cond_br = (wb_cntrl.opcode == op_br);
    assign is_control = is_cond_br | wb_cntrl.is_uncond_control;
    assign mispredict = retire & is_control &
                        ((wb_branch_prediction != wb_take_jump) |
                         (wb_check_target & wb_take_jump & (wb_pc_mux != wb_flush_pc)));
    assign bht_update = retire & is_cond_br;
    assign wb_index   = wb_pc[3:1];

    for (genvar i = 0; i < BHT_ENTRIES; i++) begin : gen_bht
        bht_counter u_counter (
            .clk   (clk),
            .reset (reset),
            .inc   (bht_update &  wb_take_jump & (wb_index == BHT_INDEX_W'(i))),
            .dec   (bht_update & ~wb_take_jump & (wb_index == BHT_INDEX_W'(i))),
            .count (bht_count[i])
        );
    end

    // Lookup reads the registered counters, so a same-cycle update is not visible.
    assign predict_taken = bht_count[fetch_pc[3:1]][1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= RS_IDLE;
            flush            <= 1'b0;
            redirect_valid   <= 1'b0;
            redirect_pc      <= 16'h0000;
            branch_count     <= 16'h0000;
            mispredict_count <= 16'h0000;
        end else begin
            case (state)
                RS_IDLE: begin
                    if (mispredict) begin
                        state          <= RS_FLUSH;
                        flush          <= 1'b1;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= wb_take_jump ? wb_pc_mux : wb_pc;
                    end
                end
                RS_FLUSH: begin
                    if (load_mem_wb) begin
                        state          <= RS_IDLE;
                        flush          <= 1'b0;
                        redirect_valid <= 1'b0;
                    end
                end
                default: begin
                    state          <= RS_IDLE;
                    flush          <= 1'b0;
                    redirect_valid <= 1'b0;
                end
            endcase
            if (bht_update) begin
                branch_count <= branch_count + 16'd1;
            end
            if (mispredict) begin
                mispredict_count <= mispredict_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_wb_branch_resolver.sv
// tb/tb_wb_branch_resolver.sv - scoreboard bench for wb_branch_resolver
module tb_wb_branch_resolver;
    import lc3b_types::*;

    logic             clk = 1'b0;
    logic             reset;
    logic             load_mem_wb;
    logic             wb_is_nop;
    lc3b_control_word wb_cntrl;
    logic             wb_branch_prediction;
    logic             wb_take_jump;
    logic [15:0]      wb_pc;
    logic [15:0]      wb_pc_mux;
    logic [15:0]      wb_flush_pc;
    logic             wb_check_target;
    logic [15:0]      fetch_pc;
    logic             predict_taken;
    logic             flush;
    logic             redirect_valid;
    logic [15:0]      redirect_pc;
    logic [15:0]      branch_count;
    logic [15:0]      mispredict_count;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] mcount;
        logic [15:0] bcount;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_high;
    logic [15:0] active_pc;

    wb_branch_resolver dut (
        .clk                  (clk),
        .reset                (reset),
        .load_mem_wb          (load_mem_wb),
        .wb_is_nop            (wb_is_nop),
        .wb_cntrl             (wb_cntrl),
        .wb_branch_prediction (wb_branch_prediction),
        .wb_take_jump         (wb_take_jump),
        .wb_pc                (wb_pc),
        .wb_pc_mux            (wb_pc_mux),
        .wb_flush_pc          (wb_flush_pc),
        .wb_check_target      (wb_check_target),
        .fetch_pc             (fetch_pc),
        .predict_taken        (predict_taken),
        .flush                (flush),
        .redirect_valid       (redirect_valid),
        .redirect_pc          (redirect_pc),
        .branch_count         (branch_count),
        .mispredict_count     (mispredict_count)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    task automatic drive(input logic ld, input logic nop, input lc3b_opcode op, input logic unc,
                         input logic pred, input logic take, input logic [15:0] pc,
                         input logic [15:0] mux, input logic [15:0] fpc, input logic chk);
        load_mem_wb          = ld;
        wb_is_nop            = nop;
        wb_cntrl.opcode      = op;
        wb_cntrl.is_uncond_control = unc;
        wb_branch_prediction = pred;
        wb_take_jump         = take;
        wb_pc                = pc;
        wb_pc_mux            = mux;
        wb_flush_pc          = fpc;
        wb_check_target      = chk;
    endtask

    task automatic idle();
        drive(1'b0, 1'b1, op_add, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " flush"}, 32'(flush), 32'd0);
        check({tag, " redirect_valid"}, 32'(redirect_valid), 32'd0);
        check({tag, " redirect_pc"}, 32'(redirect_pc), 32'h0);
        check({tag, " branch_count"}, 32'(branch_count), 32'd0);
        check({tag, " mispredict_count"}, 32'(mispredict_count), 32'd0);
        for (int i = 0; i < BHT_ENTRIES; i++)
            check($sformatf("%s bht[%0d]", tag, i), 32'(dut.bht_count[i]), 32'h1);
    endtask

    // Monitor: pops one expected redirect per rising redirect_valid and
    // checks the redirect target stays put while the flush lasts.
    initial begin
        logic prev_valid;
        exp_t e;
        prev_valid = 1'b0;
        active_pc  = 16'h0;
        forever begin
            @(negedge clk);
            if (redirect_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected redirect", 32'(redirect_pc), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    active_pc = e.pc;
                    check("redirect_pc", 32'(redirect_pc), 32'(e.pc));
                    check("mispredict_count", 32'(mispredict_count), 32'(e.mcount));
                    check("branch_count at redirect", 32'(branch_count), 32'(e.bcount));
                end
            end else if (redirect_valid) begin
                check("redirect_pc stable", 32'(redirect_pc), 32'(active_pc));
            end
            prev_valid = redirect_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset    = 1'b1;
        fetch_pc = 16'h0004;
        idle();
        step();
        step();
        reset = 1'b0;
        step();
        check_reset_state("reset");
        check("predict_taken 0x0004", 32'(predict_taken), 32'd0);

        // Taken branch predicted not-taken: redirect to its target.
        exp_q.push_back('{pc: 16'h0040, mcount: 16'd1, bcount: 16'd1});
        drive(1'b1, 1'b0, op_br, 1'b0, 1'b0, 1'b1, 16'h0006, 16'h0040, 16'h0008, 1'b0);
        step();
        idle();
        check("flush after mispredict", 32'(flush), 32'd1);
        check("bht[3] after first taken", 32'(dut.bht_count[3]), 32'h2);
        step();
        drive(1'b1, 1'b1, op_add, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
        step();
        check("flush released", 32'(flush), 32'd0);

        // Same branch three more times, correctly predicted taken.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, op_br, 1'b0, 1'b1, 1'b1, 16'h0006, 16'h0040, 16'h0040, 1'b0);
            step();
            check("no flush on correct prediction", 32'(flush), 32'd0);
        end
        idle();
        check("bht[3] saturated", 32'(dut.bht_count[3]), 32'h3);
        check("branch_count after 4", 32'(branch_count), 32'd4);
        check("mispredict_count still 1", 32'(mispredict_count), 32'd1);

        // Not-taken update with a lookup of the same index in the same cycle.
        fetch_pc = 16'h0006;
        drive(1'b1, 1'b0, op_br, 1'b0, 1'b0, 1'b0, 16'h0006, 16'h0040, 16'h0040, 1'b0);
        #1;
        check("same-cycle lookup pre-update", 32'(predict_taken), 32'd1);
        step();
        idle();
        check("bht[3] after not-taken", 32'(dut.bht_count[3]), 32'h2);
        check("branch_count after 5", 32'(branch_count), 32'd5);

        // Unconditional op with wrong predicted target.
        exp_q.push_back('{pc: 16'h1234, mcount: 16'd2, bcount: 16'd5});
        drive(1'b1, 1'b0, op_jmp, 1'b1, 1'b1, 1'b1, 16'h0100, 16'h1234, 16'h1230, 1'b1);
        step();
        idle();
        check("flush on target mismatch", 32'(flush), 32'd1);
        step();
        drive(1'b1, 1'b1, op_add, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
        step();
        check("branch_count unchanged by uncond", 32'(branch_count), 32'd5);

        // Stalled mispredicting branch in WB does nothing until it advances.
        drive(1'b0, 1'b0, op_br, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h0020, 16'h0020, 1'b0);
        step();
        step();
        check("no flush while stalled", 32'(flush), 32'd0);
        check("no count while stalled", 32'(mispredict_count), 32'd2);
        exp_q.push_back('{pc: 16'h0010, mcount: 16'd3, bcount: 16'd6});
        load_mem_wb = 1'b1;
        step();
        n_high = 0;
        if (flush) n_high++;
        drive(1'b0, 1'b0, op_br, 1'b0, 1'b0, 1'b1, 16'h0002, 16'h0300, 16'h0004, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            if (flush) n_high++;
        end
        check("flush held cycles", 32'(n_high), 32'd4);
        load_mem_wb = 1'b1;
        step();
        idle();
        check("flush dropped on advance", 32'(flush), 32'd0);
        check("mispredict in flush ignored", 32'(mispredict_count), 32'd3);
        check("branch in flush not counted", 32'(branch_count), 32'd6);
        check("bht[1] untouched in flush", 32'(dut.bht_count[1]), 32'h1);
        check("bht[0] decremented", 32'(dut.bht_count[0]), 32'h0);

        // Reset while flushing.
        exp_q.push_back('{pc: 16'h0050, mcount: 16'd4, bcount: 16'd7});
        drive(1'b1, 1'b0, op_br, 1'b0, 1'b0, 1'b1, 16'h0004, 16'h0050, 16'h0006, 1'b0);
        step();
        idle();
        check("flush before reset", 32'(flush), 32'd1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_reset_state("reset in flush");
        step();
        check("still idle after reset", 32'(flush), 32'd0);

        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
